// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared UART constants: baud divisors, frame-controller state encodings, default SYNC byte.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_rx_frame_ctrl_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int BAUD_DIV_9600   = 5208;
  localparam int BAUD_DIV_57600  = 868;
  localparam int BAUD_DIV_115200 = 434;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_buf.sv
// Payload store: DEPTH x 8 with synchronous write and registered read.
// Latency: read data appears one cycle after the address.
// Backpressure: none; writes always accepted, reads every cycle.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read, cleared on reset so rd_data starts at zero.
  always_ff @(posedge clk) begin
    if (!rstn) rdata <= 8'h00;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame hunter behind the UART receiver: SYNC, LEN, payload, XOR checksum; holds good frames for the SoC.
// Latency: frame_valid and err_* are registered, one cycle after the triggering byte/event; rd_data 1 cycle.
// Backpressure: none toward the UART; bytes arriving while a frame is held are dropped with err_ovr.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 8680,
  parameter int         AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  parameter int         LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_rcv,
  input  logic [7:0]    rx_data,
  output logic          frame_valid,
  output logic [LW-1:0] frame_len,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_len,
  output logic          err_chk,
  output logic          err_tmo,
  output logic          err_ovr,
  output logic          busy
);

  localparam int            GW       = $clog2(TIMEOUT);
  localparam logic [GW-1:0] TMO_LAST = GW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LW_ONE   = LW'(1);
  localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);

  state_t        state;
  logic [LW-1:0] len;
  logic [LW-1:0] cnt;
  logic [7:0]    chk;
  logic [GW-1:0] gap;

  logic buf_we;
  assign buf_we = (state == ST_DATA) && rx_rcv;

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (buf_we),
    .waddr (cnt[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Frame sequencer: state, length/count/checksum, gap timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_HUNT;
      len         <= '0;
      cnt         <= '0;
      chk         <= 8'h00;
      gap         <= '0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_tmo     <= 1'b0;
      err_ovr     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      err_len <= 1'b0;
      err_chk <= 1'b0;
      err_tmo <= 1'b0;
      err_ovr <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (rx_rcv && rx_data == SYNC) begin
            state <= ST_LEN;
            gap   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_LEN, ST_DATA, ST_CHK: begin
          if (rx_rcv) begin
            // A byte on the expiry cycle still wins over the timeout.
            gap <= '0;
            if (state == ST_LEN) begin
              if (rx_data == 8'h00 || rx_data > MAX_B) begin
                err_len <= 1'b1;
                state   <= ST_HUNT;
                busy    <= 1'b0;
              end else begin
                len   <= rx_data[LW-1:0];
                chk   <= rx_data;
                cnt   <= '0;
                state <= ST_DATA;
              end
            end else if (state == ST_DATA) begin
              chk <= chk ^ rx_data;
              cnt <= cnt + LW_ONE;
              if (cnt == len - LW_ONE) state <= ST_CHK;
            end else begin
              busy <= 1'b0;
              if (rx_data == chk) begin
                state       <= ST_HOLD;
                frame_valid <= 1'b1;
                frame_len   <= len;
              end else begin
                err_chk <= 1'b1;
                state   <= ST_HUNT;
              end
            end
          end else if (gap == TMO_LAST) begin
            err_tmo <= 1'b1;
            state   <= ST_HUNT;
            gap     <= '0;
            busy    <= 1'b0;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        ST_HOLD: begin
          // Incoming bytes are dropped, even one coinciding with the ack.
          if (rx_rcv) err_ovr <= 1'b1;
          if (frame_ack) begin
            state       <= ST_HUNT;
            frame_valid <= 1'b0;
            frame_len   <= '0;
          end
        end
        default: begin
          state <= ST_HUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected events queued at stimulus, popped on DUT output.
// Latency: drives just after posedge, samples at negedge or #1 after posedge.
// Backpressure: n/a.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 8680;
  localparam int AW      = 4;
  localparam int LW      = 5;

  localparam int EV_NONE  = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_LEN   = 2;
  localparam int EV_CHK   = 3;
  localparam int EV_TMO   = 4;
  localparam int EV_OVR   = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_rcv;
  logic [7:0]    rx_data;
  logic          frame_valid;
  logic [LW-1:0] frame_len;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_len, err_chk, err_tmo, err_ovr, busy;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_q[$];
  int exp_len_q[$];
  logic [7:0] pay [MAX_LEN];

  uart_rx_frame_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_rcv      (rx_rcv),
    .rx_data     (rx_data),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err_len     (err_len),
    .err_chk     (err_chk),
    .err_tmo     (err_tmo),
    .err_ovr     (err_ovr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic observe(input int code);
    int e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", code, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      check("event", code, e);
      if (e == EV_FRAME && exp_len_q.size() != 0)
        check("frame_len", {27'd0, frame_len}, exp_len_q.pop_front());
    end
  endtask

  // Output monitor: every error pulse and every frame_valid rise is matched against the scoreboard.
  logic prev_fv = 1'b0;
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      prev_fv = 1'b0;
    end else begin
      if (err_len) observe(EV_LEN);
      if (err_chk) observe(EV_CHK);
      if (err_tmo) observe(EV_TMO);
      if (err_ovr) observe(EV_OVR);
      if (frame_valid && !prev_fv) observe(EV_FRAME);
      prev_fv = frame_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rcv  = 1'b1;
    rx_data = b;
    tick();
    rx_rcv  = 1'b0;
    rx_data = 8'h00;
  endtask

  // Sends SYNC, LEN, pay[0..n-1], checksum (corrupted if bad); queues the expected outcome.
  task automatic send_frame(input int n, input bit bad);
    logic [7:0] c;
    c = 8'(n);
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(pay[i]);
      c = c ^ pay[i];
    end
    if (bad) begin
      exp_q.push_back(EV_CHK);
      send_byte(c + 8'h01);
    end else begin
      exp_q.push_back(EV_FRAME);
      exp_len_q.push_back(n);
      send_byte(c);
    end
  endtask

  task automatic read_all(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i);
      tick();
      check(tag, rd_data, pay[i]);
    end
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("valid_after_ack", frame_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rx_rcv = 1'b0; rx_data = 8'h00; frame_ack = 1'b0; rd_addr = '0;
    tick(); tick();
    check("rst_outputs", {frame_valid, frame_len, rd_data, err_len, err_chk, err_tmo, err_ovr, busy}, 0);
    rstn = 1'b1;
    tick();

    // Noise then a good 3-byte frame.
    send_byte(8'h00);
    send_byte(8'hFF);
    check("noise_busy", busy, 1'b0);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame(3, 1'b0);
    check("good_valid", frame_valid, 1'b1);
    check("good_busy", busy, 1'b0);
    read_all(3, "good_rd");
    ack();

    // Checksum error, then a 1-byte frame.
    send_frame(3, 1'b1);
    tick();
    check("chk_err_no_valid", frame_valid, 1'b0);
    pay[0] = 8'h7E;
    send_frame(1, 1'b0);
    check("len1_valid", frame_valid, 1'b1);
    read_all(1, "len1_rd");
    ack();

    // Length errors at both ends, then a maximum-length frame.
    exp_q.push_back(EV_LEN);
    send_byte(8'hA5); send_byte(8'h00);
    exp_q.push_back(EV_LEN);
    send_byte(8'hA5); send_byte(8'h11);
    tick();
    check("len_err_busy", busy, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'(i * 37 + 5);
    send_frame(MAX_LEN, 1'b0);
    read_all(MAX_LEN, "max_rd");
    ack();

    // Timeout: no byte for TIMEOUT cycles after AA.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    exp_q.push_back(EV_TMO);
    repeat (TIMEOUT - 1) tick();
    check("tmo_early", err_tmo, 1'b0);
    check("tmo_early_busy", busy, 1'b1);
    tick();
    check("tmo_pulse", err_tmo, 1'b1);
    check("tmo_busy", busy, 1'b0);
    tick();
    check("tmo_pulse_end", err_tmo, 1'b0);

    // Byte arriving exactly on the expiry cycle is processed instead.
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_byte(8'hA5); send_byte(8'h02); send_byte(pay[0]);
    repeat (TIMEOUT - 1) tick();
    send_byte(pay[1]);
    check("tmo_race_no_err", err_tmo, 1'b0);
    check("tmo_race_busy", busy, 1'b1);
    exp_q.push_back(EV_FRAME);
    exp_len_q.push_back(2);
    send_byte(8'h02 ^ pay[0] ^ pay[1]);
    check("tmo_race_valid", frame_valid, 1'b1);
    read_all(2, "tmo_race_rd");
    ack();

    // Overrun while holding, then byte coinciding with ack.
    pay[0] = 8'h01; pay[1] = 8'h02;
    send_frame(2, 1'b0);
    exp_q.push_back(EV_OVR);
    send_byte(8'hA5);
    check("ovr_still_valid", frame_valid, 1'b1);
    read_all(2, "ovr_rd");
    exp_q.push_back(EV_OVR);
    frame_ack = 1'b1;
    send_byte(8'hA5);
    frame_ack = 1'b0;
    check("ovr_ack_valid", frame_valid, 1'b0);
    check("ovr_ack_busy", busy, 1'b0);
    send_frame(2, 1'b0);
    check("after_ovr_valid", frame_valid, 1'b1);
    ack();

    // Reset mid-frame discards the partial frame.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rstn = 1'b0;
    tick();
    check("midrst_outputs", {frame_valid, frame_len, rd_data, err_len, err_chk, err_tmo, err_ovr, busy}, 0);
    rstn = 1'b1;
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h04);
    tick(); tick();
    check("midrst_no_valid", frame_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
